// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: opcodes, FSM states,
// iteration limit and divide-by-zero result constants.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   localparam logic [4:0]  MD_ITER_LAST = 5'd31;
   localparam logic [31:0] MD_DZ_LO     = 32'hFFFF_FFFF;

   function automatic logic is_mul_op(input md_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_arith(input md_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> HI/LO unit signal bundle; master is the pipeline side.
interface muldiv_if;
   logic        md_valid;
   logic [2:0]  md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        flush;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        md_done;

   modport master (output md_valid, md_op, md_a, md_b, flush,
                   input  stall, hi, lo, md_done);
   modport slave  (input  md_valid, md_op, md_a, md_b, flush,
                   output stall, hi, lo, md_done);
endinterface

// File: rtl/muldiv_div_core.sv
// Combinational single step: restoring-division step, or a shift-add multiply
// step on the same remainder/quotient pair when mul_mode is set.
module div_core (
   input  logic        mul_mode,
   input  logic [31:0] rem_in,
   input  logic [31:0] quo_in,
   input  logic [31:0] dvsr,
   output logic [31:0] rem_out,
   output logic [31:0] quo_out
);
   logic [32:0] shifted;
   logic [32:0] diff;
   logic [32:0] acc;

   always_comb begin
      shifted = {rem_in, quo_in[31]};
      diff    = shifted - {1'b0, dvsr};
      acc     = {1'b0, rem_in} + (quo_in[0] ? {1'b0, dvsr} : 33'd0);
      rem_out = rem_in;
      quo_out = quo_in;
      if (mul_mode) begin
         // rem holds the upper product half, quo shifts the multiplier out
         {rem_out, quo_out} = {acc, quo_in[31:1]};
      end else if (!diff[32]) begin
         rem_out = diff[31:0];
         quo_out = {quo_in[30:0], 1'b1};
      end else begin
         rem_out = shifted[31:0];
         quo_out = {quo_in[30:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO unit controller: sequences multiply/divide, owns HI/LO, stalls the pipe.
// Optional build macro MULDIV_SEQ_MUL_EN selects a 32-step shift-add multiply.
//   state | meaning
//   IDLE  | waiting for work; MTHI/MTLO written here
//   MUL   | multiply in progress
//   DIV   | divide in progress (or one-cycle divide-by-zero)
//   DONE  | release cycle, md_done high
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave md
);
   md_state_e   state;
   md_op_e      op;
   logic [4:0]  cnt;
   logic [31:0] rem, quo, dvsr, hi_q, lo_q;
   logic [31:0] rem_nxt, quo_nxt, a_mag, b_mag;
   logic        q_neg, r_neg, dz, md_done_q;
   logic        accept, sgn, a_neg, b_neg, mul_mode;
   logic [63:0] prod, prod_fix;

   assign op     = md_op_e'(md.md_op);
   assign accept = (state == ST_IDLE) && md.md_valid && is_arith(op);
   assign sgn    = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg  = sgn && md.md_a[31];
   assign b_neg  = sgn && md.md_b[31];
   assign a_mag  = a_neg ? (32'd0 - md.md_a) : md.md_a;
   assign b_mag  = b_neg ? (32'd0 - md.md_b) : md.md_b;

   assign md.stall   = !reset && !md.flush &&
                       ((state == ST_MUL) || (state == ST_DIV) || accept);
   assign md.hi      = hi_q;
   assign md.lo      = lo_q;
   assign md.md_done = md_done_q;

`ifdef MULDIV_SEQ_MUL_EN
   assign mul_mode = (state == ST_MUL);
   assign prod     = {rem_nxt, quo_nxt};
`else
   assign mul_mode = 1'b0;
   assign prod     = {32'd0, quo} * {32'd0, dvsr};
`endif
   assign prod_fix = q_neg ? (64'd0 - prod) : prod;

   div_core u_core (
      .mul_mode (mul_mode),
      .rem_in   (rem),
      .quo_in   (quo),
      .dvsr     (dvsr),
      .rem_out  (rem_nxt),
      .quo_out  (quo_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         dz        <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         md_done_q <= 1'b0;
      end else begin
         md_done_q <= 1'b0;
         if (md.flush) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     cnt   <= '0;
                     quo   <= a_mag;
                     dvsr  <= b_mag;
                     q_neg <= a_neg ^ b_neg;
                     r_neg <= a_neg;
                     dz    <= !is_mul_op(op) && (md.md_b == 32'd0);
                     // divide-by-zero parks the raw dividend where HI will come from
                     rem   <= (!is_mul_op(op) && (md.md_b == 32'd0)) ? md.md_a : 32'd0;
                     state <= is_mul_op(op) ? ST_MUL : ST_DIV;
                  end else if (md.md_valid && (op == OP_MTHI)) begin
                     hi_q <= md.md_a;
                  end else if (md.md_valid && (op == OP_MTLO)) begin
                     lo_q <= md.md_a;
                  end
               end
               ST_MUL: begin
`ifdef MULDIV_SEQ_MUL_EN
                  rem <= rem_nxt;
                  quo <= quo_nxt;
                  cnt <= cnt + 5'd1;
                  if (cnt == MD_ITER_LAST) begin
                     {hi_q, lo_q} <= prod_fix;
                     md_done_q    <= 1'b1;
                     state        <= ST_DONE;
                  end
`else
                  {hi_q, lo_q} <= prod_fix;
                  md_done_q    <= 1'b1;
                  state        <= ST_DONE;
`endif
               end
               ST_DIV: begin
                  if (dz) begin
                     hi_q      <= rem;
                     lo_q      <= MD_DZ_LO;
                     md_done_q <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     rem <= rem_nxt;
                     quo <= quo_nxt;
                     cnt <= cnt + 5'd1;
                     if (cnt == MD_ITER_LAST) begin
                        hi_q      <= r_neg ? (32'd0 - rem_nxt) : rem_nxt;
                        lo_q      <= q_neg ? (32'd0 - quo_nxt) : quo_nxt;
                        md_done_q <= 1'b1;
                        state     <= ST_DONE;
                     end
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random ops
// checked against an arithmetic reference of HI/LO and stall length.
module tb_muldiv_ctrl;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   muldiv_if bus ();

   muldiv_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {hi, lo} from plain arithmetic
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (op)
         3'd1: p = sa * sb;
         3'd2: p = {32'd0, a} * {32'd0, b};
         3'd3, 3'd4: begin
            if (b == 32'd0) begin
               p = {a, 32'hFFFF_FFFF};
            end else begin
               if (op == 3'd4) begin
                  sa = longint'({32'd0, a});
                  sb = longint'({32'd0, b});
               end
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   function automatic int ref_stall(input logic [2:0] op, input logic [31:0] b);
      if (op == 3'd1 || op == 3'd2) begin
`ifdef MULDIV_SEQ_MUL_EN
         return 33;
`else
         return 2;
`endif
      end
      return (b == 32'd0) ? 2 : 33;
   endfunction

   task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      int n;
      r = ref_result(op, a, b);
      @(negedge clk);
      bus.md_valid = 1'b1;
      bus.md_op    = op;
      bus.md_a     = a;
      bus.md_b     = b;
      #1;
      n = 0;
      while (bus.stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk_val("stall_len", n, ref_stall(op, b));
      chk_val("done_pulse", bus.md_done, 1);
      chk_val("hi", bus.hi, r[63:32]);
      chk_val("lo", bus.lo, r[31:0]);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      bus.md_valid = 1'b0;
      @(negedge clk);
      #1;
      chk_val("done_once", bus.md_done, 0);
      chk_val("no_restart", bus.stall, 0);
   endtask

   task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
      @(negedge clk);
      bus.md_valid = 1'b1;
      bus.md_op    = op;
      bus.md_a     = a;
      #1;
      chk_val("mt_nostall", bus.stall, 0);
      if (op == 3'd5) exp_hi = a;
      if (op == 3'd6) exp_lo = a;
      @(negedge clk);
      bus.md_valid = 1'b0;
      #1;
      chk_val("mt_hi", bus.hi, exp_hi);
      chk_val("mt_lo", bus.lo, exp_lo);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_hi = '0;
      exp_lo = '0;
      bus.md_valid = 1'b0;
      bus.md_op    = 3'd0;
      bus.md_a     = '0;
      bus.md_b     = '0;
      bus.flush    = 1'b0;
      reset        = 1'b1;
      #1;
      chk_val("rst_hi", bus.hi, 0);
      chk_val("rst_lo", bus.lo, 0);
      chk_val("rst_stall", bus.stall, 0);
      chk_val("rst_done", bus.md_done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_arith(3'd3, 32'hFFFF_FFF9, 32'd2);
      run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_arith(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_arith(3'd4, 32'd100, 32'd0);
      run_arith(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_arith(3'd3, 32'd55, 32'd0);

      // MTHI then MTLO back to back
      @(negedge clk);
      bus.md_valid = 1'b1;
      bus.md_op    = 3'd5;
      bus.md_a     = 32'h1234;
      #1;
      chk_val("mthi_stall", bus.stall, 0);
      @(negedge clk);
      bus.md_op = 3'd6;
      bus.md_a  = 32'h5678;
      #1;
      chk_val("mtlo_stall", bus.stall, 0);
      chk_val("mthi_val", bus.hi, 32'h1234);
      @(negedge clk);
      bus.md_valid = 1'b0;
      #1;
      chk_val("mtlo_val", bus.lo, 32'h5678);
      exp_hi = 32'h1234;
      exp_lo = 32'h5678;

      // flush during divide step 10
      @(negedge clk);
      bus.md_valid = 1'b1;
      bus.md_op    = 3'd3;
      bus.md_a     = 32'd1000;
      bus.md_b     = 32'd3;
      repeat (11) @(negedge clk);
      bus.flush    = 1'b1;
      bus.md_valid = 1'b0;
      #1;
      chk_val("flush_stall", bus.stall, 0);
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk_val("post_flush_stall", bus.stall, 0);
      chk_val("flush_hi", bus.hi, exp_hi);
      chk_val("flush_lo", bus.lo, exp_lo);
      for (int i = 0; i < 36; i++) begin
         chk_val("flush_no_done", bus.md_done, 0);
         @(negedge clk);
         #1;
      end
      chk_val("flush_hi_late", bus.hi, exp_hi);

      // reset mid-divide
      @(negedge clk);
      bus.md_valid = 1'b1;
      bus.md_op    = 3'd3;
      bus.md_a     = 32'd77;
      bus.md_b     = 32'd5;
      repeat (5) @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk_val("arst_hi", bus.hi, 0);
      chk_val("arst_lo", bus.lo, 0);
      chk_val("arst_stall", bus.stall, 0);
      bus.md_valid = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      run_arith(3'd4, 32'd9, 32'd4);

      // random mix
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         int mode;
         op   = 3'($urandom_range(0, 7));
         a    = $urandom;
         mode = $urandom_range(0, 7);
         case (mode)
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if (mode == 3) a = 32'h8000_0000;
         if (op >= 3'd1 && op <= 3'd4) begin
            run_arith(op, a, b);
         end else begin
            run_mt(op, a);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
